// File: rtl/ddr4_instr_decoder_pipe_pkg.sv
// ddr4_instr_decoder_pipe_pkg
// Shared constants for the registered DDR4 instruction decoder.
//   - SoftMC instruction field offsets (RAS/CAS/WE/CS/BG/BANK/ROW). The bit
//     positions assume the default widths: ROW_WIDTH=17, BANK_WIDTH=2,
//     BG_WIDTH=2 and CS_WIDTH=1.
//   - Command codes as {ras_n, cas_n, we_n}.
//   - Error codes reported on err_code.
package ddr4_instr_decoder_pipe_pkg;

  localparam int RAS_OFFSET  = 21;
  localparam int CAS_OFFSET  = 20;
  localparam int WE_OFFSET   = 19;
  localparam int CS_OFFSET   = 18;
  localparam int BG_OFFSET   = 16;
  localparam int BANK_OFFSET = 14;
  localparam int ROW_OFFSET  = 0;
  localparam int A10_BIT     = 10;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CLOSED = 2'b01,
    ERR_OPEN   = 2'b10,
    ERR_REF    = 2'b11
  } err_e;

endpackage

// File: rtl/ddr4_instr_decoder_pipe_if.sv
// ddr4_instr_decoder_pipe_if
// Bundles the dispatcher-side instruction beat and the DFI-side decoded beat.
//   master : dispatcher/phy side (drives in_valid, instr, in_phase, out_ready)
//   slave  : decoder side (drives in_ready, the DFI vectors, strobes, errors)
interface ddr4_instr_decoder_pipe_if #(
  parameter int ROW_WIDTH  = 17,
  parameter int BANK_WIDTH = 2,
  parameter int BG_WIDTH   = 2,
  parameter int CS_WIDTH   = 1,
  parameter int NSLOT      = 8,
  parameter int REP        = 2,
  parameter int CNT_WIDTH  = 16
);
  localparam int PH_W = (NSLOT / REP > 1) ? $clog2(NSLOT / REP) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 instr;
  logic [PH_W-1:0]             in_phase;
  logic                        out_valid;
  logic                        out_ready;
  logic [ROW_WIDTH*NSLOT-1:0]  dfi_address;
  logic [BANK_WIDTH*NSLOT-1:0] dfi_bank;
  logic [BG_WIDTH*NSLOT-1:0]   dfi_bankgroup;
  logic [CS_WIDTH*NSLOT-1:0]   dfi_cs_n;
  logic [NSLOT-1:0]            dfi_act_n;
  logic                        dfi_ras_n;
  logic                        dfi_cas_n;
  logic                        dfi_we_n;
  logic                        mc_rd_cas;
  logic                        mc_wr_cas;
  logic                        err_valid;
  logic [1:0]                  err_code;
  logic [CNT_WIDTH-1:0]        err_cnt;

  modport master (
    output in_valid, instr, in_phase, out_ready,
    input  in_ready, out_valid, dfi_address, dfi_bank, dfi_bankgroup,
           dfi_cs_n, dfi_act_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
           mc_rd_cas, mc_wr_cas, err_valid, err_code, err_cnt
  );

  modport slave (
    input  in_valid, instr, in_phase, out_ready,
    output in_ready, out_valid, dfi_address, dfi_bank, dfi_bankgroup,
           dfi_cs_n, dfi_act_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
           mc_rd_cas, mc_wr_cas, err_valid, err_code, err_cnt
  );
endinterface

// File: rtl/ddr4_instr_decoder_pipe_bank_tracker.sv
// ddr4_bank_tracker
// Per-bank open-row bits plus legality checks and a saturating error count.
// Optional macro: DDR4_DECODER_BLOCK_ILLEGAL_EN (illegal commands do not
// update the open bits).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_accept             a beat is accepted this cycle
//   i_drain              output consumed with no new beat behind it
//   i_cmd, i_cs          decoded {ras,cas,we} and chip-select field
//   i_bank, i_bg, i_a10  bank address, bank group, A10 (PRE-all)
//   o_illegal            combinational check result for the current beat
//   o_err_valid/o_err_code/o_err_cnt  registered error reporting
module ddr4_bank_tracker
  import ddr4_instr_decoder_pipe_pkg::*;
#(
  parameter int BANK_WIDTH = 2,
  parameter int BG_WIDTH   = 2,
  parameter int CS_WIDTH   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_accept,
  input  logic                  i_drain,
  input  logic [2:0]            i_cmd,
  input  logic [CS_WIDTH-1:0]   i_cs,
  input  logic [BANK_WIDTH-1:0] i_bank,
  input  logic [BG_WIDTH-1:0]   i_bg,
  input  logic                  i_a10,
  output logic                  o_illegal,
  output logic                  o_err_valid,
  output logic [1:0]            o_err_code,
  output logic [CNT_WIDTH-1:0]  o_err_cnt
);
  localparam int NB = 1 << (BANK_WIDTH + BG_WIDTH);

  logic [NB-1:0]                    r_open;
  logic                             r_err_valid;
  logic [1:0]                       r_err_code;
  logic [CNT_WIDTH-1:0]             r_err_cnt;
  logic [BANK_WIDTH+BG_WIDTH-1:0]   w_idx;
  logic                             w_sel;
  logic                             w_upd;
  logic [1:0]                       w_code;

  assign w_idx = {i_bg, i_bank};
  // A rank is addressed when any chip-select bit is driven low.
  assign w_sel = ~&i_cs;

  // Checks look at the open bits as they were before this beat.
  always_comb begin
    w_code = ERR_NONE;
    if (w_sel) begin
      case (i_cmd)
        CMD_RD, CMD_WR: if (!r_open[w_idx]) w_code = ERR_CLOSED;
        CMD_ACT:        if (r_open[w_idx])  w_code = ERR_OPEN;
        CMD_REF:        if (|r_open)        w_code = ERR_REF;
        default:        w_code = ERR_NONE;
      endcase
    end
  end

  assign o_illegal = (w_code != ERR_NONE);

`ifdef DDR4_DECODER_BLOCK_ILLEGAL_EN
  assign w_upd = i_accept && w_sel && !o_illegal;
`else
  assign w_upd = i_accept && w_sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_open      <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_cnt   <= '0;
    end else begin
      if (w_upd) begin
        case (i_cmd)
          CMD_ACT: r_open[w_idx] <= 1'b1;
          CMD_PRE: begin
            if (i_a10) r_open <= '0;
            else       r_open[w_idx] <= 1'b0;
          end
          default: r_open <= r_open;
        endcase
      end
      if (i_accept) begin
        r_err_valid <= o_illegal;
        r_err_code  <= w_code;
        if (o_illegal && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end else if (i_drain) begin
        r_err_valid <= 1'b0;
        r_err_code  <= ERR_NONE;
      end
    end
  end

  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;
  assign o_err_cnt   = r_err_cnt;
endmodule

// File: rtl/ddr4_instr_decoder_pipe.sv
// ddr4_instr_decoder_pipe
// Registered, flow-controlled SoftMC DDR4 instruction decoder. Each accepted
// 32-bit instruction becomes one beat of multi-slot DFI command vectors one
// cycle later; the command occupies REP slots starting at in_phase*REP and
// all other slots carry the idle pattern.
// Optional macro: DDR4_DECODER_BLOCK_ILLEGAL_EN -- illegal commands are sent
// as NOP (all slots idle, strobes low) but still flagged and counted.
// Ports:
//   clk  controller clock
//   rst  asynchronous, active-high reset
//   bus  ddr4_instr_decoder_pipe_if.slave: instruction in, DFI beat out,
//        RD/WR CAS strobes, err_valid/err_code/err_cnt
module ddr4_instr_decoder_pipe
  import ddr4_instr_decoder_pipe_pkg::*;
#(
  parameter int ROW_WIDTH  = 17,
  parameter int BANK_WIDTH = 2,
  parameter int BG_WIDTH   = 2,
  parameter int CS_WIDTH   = 1,
  parameter int NSLOT      = 8,
  parameter int REP        = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic clk,
  input  logic rst,
  ddr4_instr_decoder_pipe_if.slave bus
);
  logic [2:0]                  w_cmd;
  logic [CS_WIDTH-1:0]         w_cs;
  logic [BANK_WIDTH-1:0]       w_bank;
  logic [BG_WIDTH-1:0]         w_bg;
  logic                        w_is_act;
  logic                        w_accept;
  logic                        w_drain;
  logic                        w_illegal;
  logic                        w_block;
  logic [ROW_WIDTH-1:0]        w_addr_slot;
  logic [ROW_WIDTH*NSLOT-1:0]  w_addr_n;
  logic [BANK_WIDTH*NSLOT-1:0] w_bank_n;
  logic [BG_WIDTH*NSLOT-1:0]   w_bg_n;
  logic [CS_WIDTH*NSLOT-1:0]   w_cs_n;
  logic [NSLOT-1:0]            w_act_n;

  logic                        r_out_valid;
  logic [ROW_WIDTH*NSLOT-1:0]  r_addr;
  logic [BANK_WIDTH*NSLOT-1:0] r_bank;
  logic [BG_WIDTH*NSLOT-1:0]   r_bg;
  logic [CS_WIDTH*NSLOT-1:0]   r_cs_n;
  logic [NSLOT-1:0]            r_act_n;
  logic [2:0]                  r_ctl;
  logic                        r_rd_cas;
  logic                        r_wr_cas;

  assign w_cmd    = {bus.instr[RAS_OFFSET], bus.instr[CAS_OFFSET], bus.instr[WE_OFFSET]};
  assign w_cs     = bus.instr[CS_OFFSET +: CS_WIDTH];
  assign w_bank   = bus.instr[BANK_OFFSET +: BANK_WIDTH];
  assign w_bg     = bus.instr[BG_OFFSET +: BG_WIDTH];
  assign w_is_act = (w_cmd == CMD_ACT);

  // Reset holds the input closed so nothing is taken while state is cleared.
  assign bus.in_ready = !rst && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_drain      = r_out_valid && bus.out_ready && !w_accept;

  ddr4_bank_tracker #(
    .BANK_WIDTH (BANK_WIDTH),
    .BG_WIDTH   (BG_WIDTH),
    .CS_WIDTH   (CS_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .i_accept    (w_accept),
    .i_drain     (w_drain),
    .i_cmd       (w_cmd),
    .i_cs        (w_cs),
    .i_bank      (w_bank),
    .i_bg        (w_bg),
    .i_a10       (bus.instr[A10_BIT]),
    .o_illegal   (w_illegal),
    .o_err_valid (bus.err_valid),
    .o_err_code  (bus.err_code),
    .o_err_cnt   (bus.err_cnt)
  );

`ifdef DDR4_DECODER_BLOCK_ILLEGAL_EN
  assign w_block = w_illegal;
`else
  assign w_block = 1'b0;
`endif

  // ACT drives A16:A14 low and signals itself through act_n; every other
  // command carries RAS/CAS/WE on A16:A14.
  assign w_addr_slot = {(w_is_act ? 3'b000 : w_cmd), bus.instr[ROW_OFFSET +: ROW_WIDTH-3]};

  always_comb begin
    w_addr_n = '0;
    w_bank_n = '0;
    w_bg_n   = '0;
    w_cs_n   = '1;
    w_act_n  = '1;
    for (int s = 0; s < NSLOT; s++) begin
      if (!w_block && ((s / REP) == int'(bus.in_phase))) begin
        w_addr_n[s*ROW_WIDTH +: ROW_WIDTH]   = w_addr_slot;
        w_bank_n[s*BANK_WIDTH +: BANK_WIDTH] = w_bank;
        w_bg_n[s*BG_WIDTH +: BG_WIDTH]       = w_bg;
        w_cs_n[s*CS_WIDTH +: CS_WIDTH]       = w_cs;
        w_act_n[s]                           = !w_is_act;
      end
    end
  end

  // Output beat register: loads on accept, holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_addr      <= '0;
      r_bank      <= '0;
      r_bg        <= '0;
      r_cs_n      <= '1;
      r_act_n     <= '1;
      r_ctl       <= 3'b111;
      r_rd_cas    <= 1'b0;
      r_wr_cas    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_addr      <= w_addr_n;
      r_bank      <= w_bank_n;
      r_bg        <= w_bg_n;
      r_cs_n      <= w_cs_n;
      r_act_n     <= w_act_n;
      r_ctl       <= w_block ? 3'b111 : w_cmd;
      r_rd_cas    <= !w_block && (w_cmd == CMD_RD);
      r_wr_cas    <= !w_block && (w_cmd == CMD_WR);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.dfi_address   = r_addr;
  assign bus.dfi_bank      = r_bank;
  assign bus.dfi_bankgroup = r_bg;
  assign bus.dfi_cs_n      = r_cs_n;
  assign bus.dfi_act_n     = r_act_n;
  assign bus.dfi_ras_n     = r_ctl[2];
  assign bus.dfi_cas_n     = r_ctl[1];
  assign bus.dfi_we_n      = r_ctl[0];
  assign bus.mc_rd_cas     = r_rd_cas;
  assign bus.mc_wr_cas     = r_wr_cas;
endmodule

// File: tb/tb_ddr4_instr_decoder_pipe.sv
// tb_ddr4_instr_decoder_pipe
// Scoreboard bench: each accepted instruction is predicted by a small
// reference model (own open-bank array and error counter) and queued; every
// output handshake pops and compares the full beat.
module tb_ddr4_instr_decoder_pipe;

`ifdef DDR4_DECODER_BLOCK_ILLEGAL_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr4_instr_decoder_pipe_if bus ();

  ddr4_instr_decoder_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [135:0] addr;
    logic [15:0]  bank;
    logic [15:0]  bg;
    logic [7:0]   csn;
    logic [7:0]   actn;
    logic [2:0]   ctl;
    logic         rd;
    logic         wr;
    logic         ev;
    logic [1:0]   ec;
    logic [15:0]  cnt;
  } exp_t;

  exp_t q[$];
  bit   m_open[16];
  int   m_cnt = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] cmd, input logic cs,
                                     input logic [1:0] bg, input logic [1:0] bk,
                                     input logic [13:0] row);
    logic [31:0] i;
    i = '0;
    i[21:19] = cmd;
    i[18]    = cs;
    i[17:16] = bg;
    i[15:14] = bk;
    i[13:0]  = row;
    return i;
  endfunction

  task automatic predict(input logic [31:0] ins, input int ph, output exp_t e);
    logic [2:0] cmd;
    int idx, code;
    bit any, blk;
    cmd  = ins[21:19];
    idx  = int'(ins[17:16]) * 4 + int'(ins[15:14]);
    code = 0;
    any  = 1'b0;
    for (int b = 0; b < 16; b++) any |= m_open[b];
    if (!ins[18]) begin
      if ((cmd == 3'b101 || cmd == 3'b100) && !m_open[idx]) code = 1;
      else if (cmd == 3'b011 && m_open[idx])                code = 2;
      else if (cmd == 3'b001 && any)                        code = 3;
    end
    blk = BLK && (code != 0);
    if (!ins[18] && !blk) begin
      if (cmd == 3'b011) m_open[idx] = 1'b1;
      if (cmd == 3'b010) begin
        if (ins[10]) for (int b = 0; b < 16; b++) m_open[b] = 1'b0;
        else m_open[idx] = 1'b0;
      end
    end
    if (code != 0 && m_cnt < 65535) m_cnt++;
    e.addr = '0; e.bank = '0; e.bg = '0; e.csn = 8'hFF; e.actn = 8'hFF;
    e.ctl  = blk ? 3'b111 : cmd;
    e.rd   = !blk && cmd == 3'b101;
    e.wr   = !blk && cmd == 3'b100;
    e.ev   = (code != 0);
    e.ec   = code[1:0];
    e.cnt  = m_cnt[15:0];
    if (!blk) begin
      for (int s = ph * 2; s < ph * 2 + 2; s++) begin
        e.addr[s*17 +: 17] = {(cmd == 3'b011) ? 3'b000 : cmd, ins[13:0]};
        e.bank[s*2 +: 2]   = ins[15:14];
        e.bg[s*2 +: 2]     = ins[17:16];
        e.csn[s]           = ins[18];
        e.actn[s]          = (cmd != 3'b011);
      end
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    check("sb_nonempty", (q.size() > 0), 1'b1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("addr", bus.dfi_address, e.addr);
      check("bank", bus.dfi_bank, e.bank);
      check("bg", bus.dfi_bankgroup, e.bg);
      check("cs_n", bus.dfi_cs_n, e.csn);
      check("act_n", bus.dfi_act_n, e.actn);
      check("ctl", {bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n}, e.ctl);
      check("rd_cas", bus.mc_rd_cas, e.rd);
      check("wr_cas", bus.mc_wr_cas, e.wr);
      check("err_valid", bus.err_valid, e.ev);
      check("err_code", bus.err_code, e.ec);
      check("err_cnt", bus.err_cnt, e.cnt);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input int ph,
                      input logic ordy, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.in_phase  = ph[1:0];
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) compare_pop();
    acc = v && bus.in_ready;
    if (acc) begin
      predict(ins, ph, e);
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] ins, input int ph, output int tries);
    bit acc;
    tries = 0;
    do begin
      step(1'b1, ins, ph, 1'b1, acc);
      tries++;
    end while (!acc && tries < 50);
    check("send_accepted", acc, 1'b1);
  endtask

  logic [2:0] cmds [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};

  initial begin
    int   t;
    bit   acc;
    logic [135:0] snap_addr;
    logic [7:0]   snap_csn;

    bus.in_valid = 1'b0; bus.instr = '0; bus.in_phase = '0; bus.out_ready = 1'b0;
    for (int b = 0; b < 16; b++) m_open[b] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_err_valid", bus.err_valid, 1'b0);
    check("rst_err_code", bus.err_code, 2'b00);
    check("rst_err_cnt", bus.err_cnt, 16'd0);
    check("rst_cs_n", bus.dfi_cs_n, 8'hFF);
    check("rst_act_n", bus.dfi_act_n, 8'hFF);
    check("rst_addr", bus.dfi_address, 136'd0);
    rst = 1'b0;

    // Directed: ACT, RD at phase 2, RD to a closed bank
    send(mk(3'b011, 1'b0, 2'd1, 2'd3, 14'h1A5), 0, t);
    step(1'b0, '0, 0, 1'b1, acc);
    check("tp_act_n", bus.dfi_act_n, 8'hFC);
    send(mk(3'b101, 1'b0, 2'd1, 2'd3, 14'h040), 2, t);
    send(mk(3'b101, 1'b0, 2'd0, 2'd0, 14'h000), 1, t);
    step(1'b0, '0, 0, 1'b1, acc);
    check("tp_closed_code", bus.err_code, 2'b01);
    // ACT b2 twice, PRE all, REF
    send(mk(3'b011, 1'b0, 2'd0, 2'd2, 14'h0011), 3, t);
    send(mk(3'b011, 1'b0, 2'd0, 2'd2, 14'h0022), 0, t);
    send(mk(3'b010, 1'b0, 2'd0, 2'd0, 14'h0400), 0, t);
    send(mk(3'b001, 1'b0, 2'd0, 2'd0, 14'h0000), 1, t);

    // Randomised stream with random backpressure
    for (int k = 0; k < 40; k++) begin
      step(1'($urandom_range(0, 3) != 0),
           mk(cmds[$urandom_range(0, 6)], 1'($urandom_range(0, 4) == 0),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              14'($urandom_range(0, 16383))),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0), acc);
    end
    for (int k = 0; k < 5; k++) step(1'b0, '0, 0, 1'b1, acc);
    check("drain1_empty", q.size(), 0);

    // Stall: beat held three cycles, then back-to-back without bubbles
    send(mk(3'b011, 1'b0, 2'd2, 2'd1, 14'h0123), 1, t);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, mk(3'b101, 1'b0, 2'd2, 2'd1, 14'h0008), 1, 1'b0, acc);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_out_valid", bus.out_valid, 1'b1);
      if (k == 0) begin
        snap_addr = bus.dfi_address;
        snap_csn  = bus.dfi_cs_n;
      end else begin
        check("stall_addr_hold", bus.dfi_address, snap_addr);
        check("stall_csn_hold", bus.dfi_cs_n, snap_csn);
      end
    end
    for (int k = 0; k < 4; k++) begin
      send(mk((k % 2 == 0) ? 3'b101 : 3'b100, 1'b0, 2'd2, 2'd1, 14'(k * 8)), k, t);
      check("no_bubble", t, 1);
    end

    // Reset mid-stream with a beat held in the output register
    send(mk(3'b011, 1'b0, 2'd0, 2'd1, 14'h0055), 2, t);
    step(1'b0, '0, 0, 1'b0, acc);
    check("pre_rst_out_valid", bus.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_err_cnt", bus.err_cnt, 16'd0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    q.delete();
    for (int b = 0; b < 16; b++) m_open[b] = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    send(mk(3'b101, 1'b0, 2'd0, 2'd1, 14'h0010), 0, t);
    step(1'b0, '0, 0, 1'b1, acc);
    check("postrst_code", bus.err_code, 2'b01);

    for (int k = 0; k < 5; k++) step(1'b0, '0, 0, 1'b1, acc);
    check("final_empty", q.size(), 0);
    check("final_out_valid", bus.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr4_instr_decoder_pipe.md
Name: ddr4_instr_decoder_pipe

Overview:
- Registered, flow-controlled successor to the SoftMC DDR4 instruction decoder.
- Decodes one 32-bit SoftMC instruction per accepted beat into multi-slot DFI command vectors: address, bank, bank group, cs_n, act_n, plus RD/WR CAS strobes.
- Adds a selectable phase slot, bank-group field, idle slots with defined (non-x) values, and a per-bank open-row tracker that flags illegal sequences.
- Sits between the instruction dispatcher and the DFI phy interface.

Parameters:
ROW_WIDTH, 17, DDR4 address pins incl. A16:A14 (RAS/CAS/WE multiplex)
BANK_WIDTH, 2, bank address bits
BG_WIDTH, 2, bank group bits
CS_WIDTH, 1, chip selects
NSLOT, 8, DFI slots per controller clock
REP, 2, consecutive slots one command occupies; NSLOT % REP == 0
CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  controller clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  instruction valid
in_ready  out  1  decoder can accept
instr  in  32  SoftMC instruction; fields at the `*_OFFSET constants; row/col at [ROW_WIDTH-4:0]
in_phase  in  clog2(NSLOT/REP)  command position; slots in_phase*REP .. +REP-1
out_valid  out  1  decoded beat valid
out_ready  in  1  downstream accepts
dfi_address  out  ROW_WIDTH*NSLOT  per-pin slot vectors
dfi_bank  out  BANK_WIDTH*NSLOT
dfi_bankgroup  out  BG_WIDTH*NSLOT
dfi_cs_n  out  CS_WIDTH*NSLOT
dfi_act_n  out  NSLOT
dfi_ras_n, dfi_cas_n, dfi_we_n  out  1 each  raw decoded control
mc_rd_cas, mc_wr_cas  out  1 each  read/write CAS in beat
err_valid  out  1  beat carries illegal command
err_code  out  2  01 RD/WR to closed bank, 10 ACT to open bank, 11 REF/PREA-less REF with open banks
err_cnt  out  CNT_WIDTH  saturating illegal-command count

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, err_valid=0, err_code=0, err_cnt=0, all banks closed.
  - Output vectors take the idle pattern; in_ready=0 while rst is high.
- Handshake:
  - in_ready = !out_valid || out_ready. Accept = in_valid && in_ready.
  - Latency is 1 cycle: accepted beat appears on the next edge; outputs hold stable while out_valid && !out_ready.
- Decode (ras/cas/we from instr; cs from CS field):
  - ACT = 011, RD = 101, WR = 100, PRE = 010, REF = 001, MRS = 000, NOP = 111.
- Slot fill:
  - Idle slots: cs_n=1, act_n=1, address/bank/bg=0.
  - Command slots: cs_n=CS field; bank/bg from fields.
  - Address bits [ROW_WIDTH-4:0] from instr.
  - A16:A14: for ACT, 0 with act_n=0; otherwise the RAS/CAS/WE bits with act_n=1.
- Strobes: mc_rd_cas=1 iff RD and act_n=1; mc_wr_cas=1 iff WR and act_n=1.
- Tracker: 2^(BANK_WIDTH+BG_WIDTH) open bits, updated on accept, and only when CS field is low (selected).
  - ACT sets the bank; PRE with A10=0 clears it; PRE with A10=1 clears all.
- Checks: evaluated against state before the update. err_valid/err_code are registered with the same beat. err_cnt increments on accept of an illegal command and saturates at all-ones.
- Simultaneous out handshake and new accept: pass-through without a bubble.
- Reset mid-stream discards the registered beat.

Optional Feature:
- DDR4_DECODER_BLOCK_ILLEGAL_EN defined: an illegal command is emitted as NOP (all slots idle, strobes 0) but still flagged and counted. The tracker is not updated for it.
- Undefined: illegal commands are forwarded unchanged and only flagged.

Decomposition:
- softMC.inc holds instruction offsets (RAS/CAS/WE/CS/ROW) and the new BG_OFFSET, plus the command-code and err_code constants.
- One sub-module, ddr4_bank_tracker: open-bit array, check logic and err_cnt.

Test Plan:
- ACT bank3 bg1 row 0x1A5, in_phase=0, out_ready=1 -> next cycle: act_n=8'b11111100; slots 0-1 A16:A14=000, bank=3, bg=1; slots 2-7 idle; err_valid=0.
- RD bank3 bg1 col 0x40, in_phase=2 -> slots 4-5 cs_n=0, A16:A14=101, mc_rd_cas=1, act_n all 1.
- RD bank0 with no prior ACT -> err_valid=1, err_code=01, err_cnt=1; with DDR4_DECODER_BLOCK_ILLEGAL_EN all slots idle and mc_rd_cas=0.
- ACT b2, ACT b2 again, then PRE A10=1, then REF -> second ACT gives err_code=10; REF gives no error.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; on release, back-to-back beats with no bubble.
- Assert rst mid-stream with out_valid=1 -> out_valid drops immediately, err_cnt=0; a later RD to the previously open bank flags 01.
